// File: rtl/poly_ctrl.sv
// Sequencing controller for the 8-bit A/B/C/X + add/multiply datapath.
// Collects four operands via a go handshake, then runs A*X^2+B*X+C (mode 0) or (A+B)*(C+X) (mode 1).
module poly_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic       mode,
  output logic       ld_a,
  output logic       ld_b,
  output logic       ld_c,
  output logic       ld_x,
  output logic       ld_alu_out,
  output logic       ld_r,
  output logic       alu_op,
  output logic [1:0] alu_select_a,
  output logic [1:0] alu_select_b,
  output logic       busy,
  output logic       done
);

  // state         | meaning
  // S_LOAD_n      | capture data_in into operand n, wait for go
  // S_LOAD_n_WAIT | keep capturing, wait for go to fall
  // M0_Ck         | mode 0 compute step k (5 steps)
  // M1_Ck         | mode 1 compute step k (3 steps)
  // S_DONE        | result held, wait for go
  // S_DONE_WAIT   | result held, wait for go to fall
  typedef enum logic [4:0] {
    S_LOAD_A, S_LOAD_A_WAIT, S_LOAD_B, S_LOAD_B_WAIT,
    S_LOAD_C, S_LOAD_C_WAIT, S_LOAD_X, S_LOAD_X_WAIT,
    M0_C0, M0_C1, M0_C2, M0_C3, M0_C4,
    M1_C0, M1_C1, M1_C2,
    S_DONE, S_DONE_WAIT
  } state_t;

  typedef struct packed {
    logic       ld_a;
    logic       ld_b;
    logic       ld_c;
    logic       ld_x;
    logic       ld_alu_out;
    logic       ld_r;
    logic       alu_op;
    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic       busy;
    logic       done;
  } ctrl_t;

  state_t state, state_nxt;
  ctrl_t  ctrl;

  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_LOAD_A, S_LOAD_A_WAIT: c.ld_a = 1'b1;
      S_LOAD_B, S_LOAD_B_WAIT: c.ld_b = 1'b1;
      S_LOAD_C, S_LOAD_C_WAIT: c.ld_c = 1'b1;
      S_LOAD_X, S_LOAD_X_WAIT: c.ld_x = 1'b1;
      M0_C0, M0_C1: begin
        c.sel_a = 2'd0; c.sel_b = 2'd3; c.alu_op = 1'b1;
        c.ld_a = 1'b1; c.ld_alu_out = 1'b1; c.busy = 1'b1;
      end
      M0_C2: begin
        c.sel_a = 2'd1; c.sel_b = 2'd3; c.alu_op = 1'b1;
        c.ld_b = 1'b1; c.ld_alu_out = 1'b1; c.busy = 1'b1;
      end
      M0_C3, M1_C0: begin
        c.sel_a = 2'd0; c.sel_b = 2'd1;
        c.ld_a = 1'b1; c.ld_alu_out = 1'b1; c.busy = 1'b1;
      end
      M0_C4: begin
        c.sel_a = 2'd0; c.sel_b = 2'd2; c.ld_r = 1'b1; c.busy = 1'b1;
      end
      M1_C1: begin
        c.sel_a = 2'd2; c.sel_b = 2'd3;
        c.ld_b = 1'b1; c.ld_alu_out = 1'b1; c.busy = 1'b1;
      end
      M1_C2: begin
        c.sel_a = 2'd0; c.sel_b = 2'd1; c.alu_op = 1'b1;
        c.ld_r = 1'b1; c.busy = 1'b1;
      end
      S_DONE, S_DONE_WAIT: c.done = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  // The program choice is latched in the state itself, so later mode changes are inert.
  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD_A:      if (go)  state_nxt = S_LOAD_A_WAIT;
      S_LOAD_A_WAIT: if (!go) state_nxt = S_LOAD_B;
      S_LOAD_B:      if (go)  state_nxt = S_LOAD_B_WAIT;
      S_LOAD_B_WAIT: if (!go) state_nxt = S_LOAD_C;
      S_LOAD_C:      if (go)  state_nxt = S_LOAD_C_WAIT;
      S_LOAD_C_WAIT: if (!go) state_nxt = S_LOAD_X;
      S_LOAD_X:      if (go)  state_nxt = S_LOAD_X_WAIT;
      S_LOAD_X_WAIT: if (!go) state_nxt = mode ? M1_C0 : M0_C0;
      M0_C0:         state_nxt = M0_C1;
      M0_C1:         state_nxt = M0_C2;
      M0_C2:         state_nxt = M0_C3;
      M0_C3:         state_nxt = M0_C4;
      M0_C4:         state_nxt = S_DONE;
      M1_C0:         state_nxt = M1_C1;
      M1_C1:         state_nxt = M1_C2;
      M1_C2:         state_nxt = S_DONE;
      S_DONE:        if (go)  state_nxt = S_DONE_WAIT;
      S_DONE_WAIT:   if (!go) state_nxt = S_LOAD_A;
      default:       state_nxt = S_LOAD_A;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_LOAD_A;
      ctrl  <= decode(S_LOAD_A);
    end else begin
      state <= state_nxt;
      ctrl  <= decode(state_nxt);
    end
  end

  assign ld_a         = ctrl.ld_a;
  assign ld_b         = ctrl.ld_b;
  assign ld_c         = ctrl.ld_c;
  assign ld_x         = ctrl.ld_x;
  assign ld_alu_out   = ctrl.ld_alu_out;
  assign ld_r         = ctrl.ld_r;
  assign alu_op       = ctrl.alu_op;
  assign alu_select_a = ctrl.sel_a;
  assign alu_select_b = ctrl.sel_b;
  assign busy         = ctrl.busy;
  assign done         = ctrl.done;

endmodule

// File: tb/tb_poly_ctrl.sv
// Bench for poly_ctrl: drives a behavioural datapath from the controller and compares
// every control output against an abstract phase/step model each cycle.
module tb_poly_ctrl;

  logic       clk = 1'b0;
  logic       reset, go, mode;
  logic       ld_a, ld_b, ld_c, ld_x, ld_alu_out, ld_r, alu_op, busy, done;
  logic [1:0] alu_select_a, alu_select_b;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  poly_ctrl dut (
    .clk(clk), .reset(reset), .go(go), .mode(mode),
    .ld_a(ld_a), .ld_b(ld_b), .ld_c(ld_c), .ld_x(ld_x),
    .ld_alu_out(ld_alu_out), .ld_r(ld_r), .alu_op(alu_op),
    .alu_select_a(alu_select_a), .alu_select_b(alu_select_b),
    .busy(busy), .done(done)
  );

  // Behavioural datapath steered by the controller.
  logic [7:0] data_in, ra, rb, rc, rx, rr, opa, opb, alu_res;

  function automatic logic [7:0] pick(input logic [1:0] s);
    case (s)
      2'd0: return ra;
      2'd1: return rb;
      2'd2: return rc;
      default: return rx;
    endcase
  endfunction

  always_comb begin
    opa = pick(alu_select_a);
    opb = pick(alu_select_b);
    alu_res = alu_op ? opa * opb : opa + opb;
  end

  always @(posedge clk) begin
    if (ld_a) ra <= ld_alu_out ? alu_res : data_in;
    if (ld_b) rb <= ld_alu_out ? alu_res : data_in;
    if (ld_c) rc <= data_in;
    if (ld_x) rx <= data_in;
    if (ld_r) rr <= alu_res;
  end

  // Abstract model: phase 0 = loading operand midx, 1 = compute step mstep, 2 = done.
  int   mph = 0, midx = 0, mstep = 0;
  logic mwait = 1'b0, mprog = 1'b0;

  // Program steps as {dest (0=A,1=B,2=R), sel_a, sel_b, op}.
  int p0 [5][4] = '{'{0,0,3,1}, '{0,0,3,1}, '{1,1,3,1}, '{0,0,1,0}, '{2,0,2,0}};
  int p1 [3][4] = '{'{0,0,1,0}, '{1,2,3,0}, '{2,0,1,1}};

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mph = 0; midx = 0; mwait = 1'b0; mstep = 0;
    end else begin
      case (mph)
        0: if (!mwait) begin
             if (go) mwait = 1'b1;
           end else if (!go) begin
             mwait = 1'b0;
             if (midx == 3) begin mph = 1; mprog = mode; mstep = 0; end
             else midx = midx + 1;
           end
        1: begin
             if (mstep == (mprog ? 2 : 4)) begin mph = 2; mwait = 1'b0; end
             else mstep = mstep + 1;
           end
        default: if (!mwait) begin
             if (go) mwait = 1'b1;
           end else if (!go) begin
             mph = 0; midx = 0; mwait = 1'b0;
           end
      endcase
    end
  end

  function automatic logic [12:0] mexp();
    logic la, lb, lc, lx, lao, lr, op, bs, dn;
    logic [1:0] sa, sb;
    int st [4];
    {la, lb, lc, lx, lao, lr, op, bs, dn} = '0;
    sa = 2'd0; sb = 2'd0;
    if (mph == 0) begin
      la = (midx == 0); lb = (midx == 1); lc = (midx == 2); lx = (midx == 3);
    end else if (mph == 1) begin
      st = mprog ? p1[mstep] : p0[mstep];
      sa = 2'(st[1]); sb = 2'(st[2]); op = (st[3] != 0); bs = 1'b1;
      la = (st[0] == 0); lb = (st[0] == 1); lr = (st[0] == 2);
      lao = (st[0] != 2);
    end else dn = 1'b1;
    return {la, lb, lc, lx, lao, lr, op, sa, sb, bs, dn};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      logic [12:0] got, exp_v;
      got = {ld_a, ld_b, ld_c, ld_x, ld_alu_out, ld_r, alu_op,
             alu_select_a, alu_select_b, busy, done};
      exp_v = mexp();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL ctrl t=%0t got=%b expected=%b", $time, got, exp_v);
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp_v);
    checks++;
    if (got != exp_v) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp_v);
    end
  endtask

  function automatic logic [7:0] poly(input logic m, input int a, b, c, x);
    int r;
    r = m ? (a + b) * (c + x) : a * x * x + b * x + c;
    return 8'(r);
  endfunction

  task automatic load_op(input logic [7:0] v, input int hold);
    @(negedge clk);
    data_in = v; go = 1'b1;
    repeat (hold) @(negedge clk);
    go = 1'b0;
  endtask

  task automatic load_all(input int a, b, c, x, input int hold);
    load_op(8'(a), hold); load_op(8'(b), hold);
    load_op(8'(c), hold); load_op(8'(x), hold);
  endtask

  task automatic run(input logic m, input int a, b, c, x, input int hold,
                     input logic toggle, input int lit);
    int cnt, nb;
    logic [7:0] held;
    mode = m;
    load_all(a, b, c, x, hold);
    cnt = 0; nb = 0;
    do begin
      @(negedge clk);
      cnt++;
      if (busy) nb++;
      if (toggle) mode = ~mode;
    end while (!done && cnt < 20);
    chk("latency", cnt, m ? 4 : 6);
    chk("busy_cycles", nb, m ? 3 : 5);
    chk("result_model", rr, poly(m, a, b, c, x));
    chk("result_literal", rr, lit);
    held = rr;
    if (toggle) begin
      repeat (3) begin @(negedge clk); mode = ~mode; end
      chk("done_hold", done, 1);
      chk("result_hold", rr, held);
    end
    @(negedge clk); go = 1'b1;
    repeat (3) @(negedge clk);
    chk("done_wait_done", done, 1);
    chk("done_wait_lda", ld_a, 0);
    go = 1'b0;
    @(negedge clk);
    chk("back_load_a", ld_a, 1);
    chk("back_done", done, 0);
  endtask

  initial begin
    reset = 1'b1; go = 1'b0; mode = 1'b0; data_in = 8'd0;
    repeat (2) @(negedge clk);
    chk("rst_ld_a", ld_a, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ld_b", ld_b, 0);
    reset = 1'b0; chk_en = 1'b1;

    run(1'b0, 2, 3, 4, 5, 1, 1'b0, 69);
    run(1'b1, 2, 3, 4, 5, 1, 1'b0, 45);
    run(1'b0, 16, 0, 0, 16, 1, 1'b0, 0);
    run(1'b1, 200, 100, 1, 1, 1, 1'b0, 88);
    run(1'b0, 2, 3, 4, 5, 10, 1'b0, 69);

    // Abort mid-compute with an asynchronous reset during the third mode-0 step.
    mode = 1'b0;
    load_all(2, 3, 4, 5, 1);
    repeat (3) @(negedge clk);
    chk("m0c2_ld_b", ld_b, 1);
    chk("m0c2_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_ld_a", ld_a, 1);
    chk("async_ld_b", ld_b, 0);
    chk("async_busy", busy, 0);
    chk("async_done", done, 0);
    @(negedge clk);
    reset = 1'b0;

    run(1'b1, 7, 9, 3, 2, 1, 1'b0, 80);
    run(1'b0, 3, 1, 2, 4, 1, 1'b1, 54);
    run(1'b1, 4, 6, 1, 2, 2, 1'b1, 30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
